// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage
// Registered decode/control stage of the RV32I five-stage pipeline, sitting
// between the IF/ID register and execute.
//   Parameters : XLEN  - width of the PC carried with the instruction
//                EN_M  - 1 decodes RV32M (R-type funct7 = 0000001) as legal
//                CNT_W - width of the saturating load-use bubble counter
//   Inputs     : clk, rst_n (async, active-low), if_valid/instr/if_pc from
//                IF/ID, flush (redirect kill), ex_ready (execute consumes)
//   Outputs    : id_ready (combinational accept), ex_valid plus the ex_*
//                control bundle held in the ID/EX register, bubble_cnt
module id_ctrl_stage #(
  parameter int XLEN  = 32,
  parameter int EN_M  = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  if_pc,
  output logic             id_ready,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic             ex_alu_src,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_reg_write,
  output logic             ex_mem_to_reg,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic [1:0]       ex_alu_op,
  output logic [2:0]       ex_imm_type,
  output logic [4:0]       ex_rd,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7_5,
  output logic [XLEN-1:0]  ex_pc,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_W'(1);
  endfunction

  // ---- stage p0: combinational decode of the incoming instruction ----
  logic [6:0] opcode_p0;
  logic [6:0] funct7_p0;
  logic [4:0] rs1_p0;
  logic [4:0] rs2_p0;

  assign opcode_p0 = instr[6:0];
  assign funct7_p0 = instr[31:25];
  assign rs1_p0    = instr[19:15];
  assign rs2_p0    = instr[24:20];

  logic       alu_src_p0, mem_read_p0, mem_write_p0, reg_write_p0;
  logic       mem_to_reg_p0, branch_p0, jump_p0, illegal_p0;
  logic [1:0] alu_op_p0;
  logic [2:0] imm_type_p0;
  logic       rs1_use_p0, rs2_use_p0;

  always_comb begin
    alu_src_p0    = 1'b0;
    mem_read_p0   = 1'b0;
    mem_write_p0  = 1'b0;
    reg_write_p0  = 1'b0;
    mem_to_reg_p0 = 1'b0;
    branch_p0     = 1'b0;
    jump_p0       = 1'b0;
    illegal_p0    = 1'b0;
    alu_op_p0     = 2'b00;
    imm_type_p0   = 3'b000;
    rs1_use_p0    = 1'b0;
    rs2_use_p0    = 1'b0;
    case (opcode_p0)
      OP_R: begin
        // Register usage follows the opcode even when funct7 is rejected.
        rs1_use_p0 = 1'b1;
        rs2_use_p0 = 1'b1;
        if (funct7_p0 == 7'b0000000 || funct7_p0 == 7'b0100000) begin
          alu_op_p0    = 2'b10;
          reg_write_p0 = 1'b1;
          imm_type_p0  = 3'b111;
        end else if ((EN_M != 0) && funct7_p0 == 7'b0000001) begin
          alu_op_p0    = 2'b11;
          reg_write_p0 = 1'b1;
          imm_type_p0  = 3'b111;
        end else begin
          illegal_p0 = 1'b1;
        end
      end
      OP_I: begin
        alu_src_p0   = 1'b1;
        alu_op_p0    = 2'b10;
        reg_write_p0 = 1'b1;
        rs1_use_p0   = 1'b1;
      end
      OP_LOAD: begin
        alu_src_p0    = 1'b1;
        mem_read_p0   = 1'b1;
        reg_write_p0  = 1'b1;
        mem_to_reg_p0 = 1'b1;
        rs1_use_p0    = 1'b1;
      end
      OP_STORE: begin
        alu_src_p0   = 1'b1;
        mem_write_p0 = 1'b1;
        imm_type_p0  = 3'b001;
        rs1_use_p0   = 1'b1;
        rs2_use_p0   = 1'b1;
      end
      OP_BRANCH: begin
        alu_op_p0   = 2'b01;
        branch_p0   = 1'b1;
        imm_type_p0 = 3'b010;
        rs1_use_p0  = 1'b1;
        rs2_use_p0  = 1'b1;
      end
      OP_JAL: begin
        jump_p0      = 1'b1;
        reg_write_p0 = 1'b1;
        imm_type_p0  = 3'b100;
      end
      OP_JALR: begin
        alu_src_p0   = 1'b1;
        jump_p0      = 1'b1;
        reg_write_p0 = 1'b1;
        rs1_use_p0   = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        alu_src_p0   = 1'b1;
        reg_write_p0 = 1'b1;
        imm_type_p0  = 3'b011;
      end
      OP_FENCE: ;
      default: illegal_p0 = 1'b1;
    endcase
  end

  // Load-use: the held entry is a load whose rd the incoming instr reads.
  logic hz_p0, vld_p0, bubble_p0;

  assign hz_p0 = ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                 ((rs1_use_p0 & (rs1_p0 == ex_rd)) |
                  (rs2_use_p0 & (rs2_p0 == ex_rd)));
  assign id_ready  = ~flush & ~hz_p0 & (~ex_valid | ex_ready);
  assign vld_p0    = if_valid & id_ready;
  assign bubble_p0 = hz_p0 & ex_ready & if_valid & ~flush;

  // ---- stage p1: ID/EX register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_branch     <= 1'b0;
      ex_jump       <= 1'b0;
      ex_alu_op     <= 2'b00;
      ex_imm_type   <= 3'b000;
      ex_rd         <= 5'd0;
      ex_rs1        <= 5'd0;
      ex_rs2        <= 5'd0;
      ex_funct3     <= 3'b000;
      ex_funct7_5   <= 1'b0;
      ex_pc         <= '0;
      ex_illegal    <= 1'b0;
      bubble_cnt    <= '0;
    end else begin
      // Flush wins over everything; vld_p0 is already low under flush.
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (vld_p0) begin
        ex_valid      <= 1'b1;
        ex_alu_src    <= alu_src_p0;
        ex_mem_read   <= mem_read_p0;
        ex_mem_write  <= mem_write_p0;
        ex_reg_write  <= reg_write_p0;
        ex_mem_to_reg <= mem_to_reg_p0;
        ex_branch     <= branch_p0;
        ex_jump       <= jump_p0;
        ex_alu_op     <= alu_op_p0;
        ex_imm_type   <= imm_type_p0;
        ex_rd         <= instr[11:7];
        ex_rs1        <= rs1_p0;
        ex_rs2        <= rs2_p0;
        ex_funct3     <= instr[14:12];
        ex_funct7_5   <= instr[30];
        ex_pc         <= if_pc;
        ex_illegal    <= illegal_p0;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
      if (bubble_p0) bubble_cnt <= sat_inc(bubble_cnt);
    end
  end

endmodule

// File: tb/tb_id_ctrl_stage.sv
module tb_id_ctrl_stage;

  typedef struct packed {
    logic        illegal;
    logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump;
    logic [1:0]  alu_op;
    logic [2:0]  imm;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f75;
    logic [31:0] pc;
  } bundle_t;

  typedef struct packed {
    bundle_t b0;   // expected for EN_M = 0 instance
    bundle_t b1;   // expected for EN_M = 1 instance
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] if_pc = '0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b0;

  logic id_ready, ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
  logic ex_mem_to_reg, ex_branch, ex_jump, ex_funct7_5, ex_illegal;
  logic [1:0] ex_alu_op;
  logic [2:0] ex_imm_type, ex_funct3;
  logic [4:0] ex_rd, ex_rs1, ex_rs2;
  logic [31:0] ex_pc;
  logic [15:0] bubble_cnt;

  logic id_ready_m, ex_valid_m, ex_alu_src_m, ex_mem_read_m, ex_mem_write_m, ex_reg_write_m;
  logic ex_mem_to_reg_m, ex_branch_m, ex_jump_m, ex_funct7_5_m, ex_illegal_m;
  logic [1:0] ex_alu_op_m;
  logic [2:0] ex_imm_type_m, ex_funct3_m;
  logic [4:0] ex_rd_m, ex_rs1_m, ex_rs2_m;
  logic [31:0] ex_pc_m;
  logic [2:0] bubble_cnt_m;

  always #5 clk = ~clk;

  id_ctrl_stage #(.XLEN(32), .EN_M(0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .instr(instr), .if_pc(if_pc),
    .id_ready(id_ready), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_alu_src(ex_alu_src), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_alu_op(ex_alu_op), .ex_imm_type(ex_imm_type), .ex_rd(ex_rd),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_funct3(ex_funct3), .ex_funct7_5(ex_funct7_5),
    .ex_pc(ex_pc), .ex_illegal(ex_illegal), .bubble_cnt(bubble_cnt));

  // Second instance: M extension enabled and a narrow counter to reach saturation.
  id_ctrl_stage #(.XLEN(32), .EN_M(1), .CNT_W(3)) dut_m (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .instr(instr), .if_pc(if_pc),
    .id_ready(id_ready_m), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid_m),
    .ex_alu_src(ex_alu_src_m), .ex_mem_read(ex_mem_read_m), .ex_mem_write(ex_mem_write_m),
    .ex_reg_write(ex_reg_write_m), .ex_mem_to_reg(ex_mem_to_reg_m), .ex_branch(ex_branch_m),
    .ex_jump(ex_jump_m), .ex_alu_op(ex_alu_op_m), .ex_imm_type(ex_imm_type_m), .ex_rd(ex_rd_m),
    .ex_rs1(ex_rs1_m), .ex_rs2(ex_rs2_m), .ex_funct3(ex_funct3_m), .ex_funct7_5(ex_funct7_5_m),
    .ex_pc(ex_pc_m), .ex_illegal(ex_illegal_m), .bubble_cnt(bubble_cnt_m));

  bundle_t act0, act1;
  assign act0 = {ex_illegal, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write,
                 ex_mem_to_reg, ex_branch, ex_jump, ex_alu_op, ex_imm_type, ex_rd,
                 ex_rs1, ex_rs2, ex_funct3, ex_funct7_5, ex_pc};
  assign act1 = {ex_illegal_m, ex_alu_src_m, ex_mem_read_m, ex_mem_write_m, ex_reg_write_m,
                 ex_mem_to_reg_m, ex_branch_m, ex_jump_m, ex_alu_op_m, ex_imm_type_m, ex_rd_m,
                 ex_rs1_m, ex_rs2_m, ex_funct3_m, ex_funct7_5_m, ex_pc_m};

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  exp_t q[$];
  logic       mv = 1'b0, m_mr = 1'b0;
  logic [4:0] m_rd = '0;
  int         mb0 = 0, mb1 = 0;
  logic [31:0] pc_ctr = 32'h1000;

  // Control word: {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jump, alu_op, imm}
  function automatic bundle_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                         input bit en_m);
    bundle_t b;
    logic [11:0] cw;
    logic [6:0]  f7;
    b = '0;
    f7 = ins[31:25];
    cw = '0;
    case (ins[6:0])
      7'h33: begin
        if (f7 == 7'h00 || f7 == 7'h20) cw = 12'b0001000_10_111;
        else if (en_m && f7 == 7'h01)   cw = 12'b0001000_11_111;
        else b.illegal = 1'b1;
      end
      7'h13: cw = 12'b1001000_10_000;
      7'h03: cw = 12'b1101100_00_000;
      7'h23: cw = 12'b1010000_00_001;
      7'h63: cw = 12'b0000010_01_010;
      7'h6F: cw = 12'b0001001_00_100;
      7'h67: cw = 12'b1001001_00_000;
      7'h37, 7'h17: cw = 12'b1001000_00_011;
      7'h0F: cw = '0;
      default: b.illegal = 1'b1;
    endcase
    {b.alu_src, b.mem_read, b.mem_write, b.reg_write, b.mem_to_reg,
     b.branch, b.jump, b.alu_op, b.imm} = cw;
    b.rd  = ins[11:7];
    b.rs1 = ins[19:15];
    b.rs2 = ins[24:20];
    b.f3  = ins[14:12];
    b.f75 = ins[30];
    b.pc  = pc;
    return b;
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {7'h33, 7'h23, 7'h63};
  endfunction

  // One clock cycle of stimulus; called at posedge+1.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic fl, input logic er);
    logic hz, rdy, acc, nv, n_mr;
    logic [4:0] n_rd;
    int nb0, nb1;
    bundle_t b0, b1;
    if_valid = iv; instr = ins; if_pc = pc_ctr; flush = fl; ex_ready = er;
    #1;
    hz = mv && m_mr && (m_rd != 0) &&
         ((reads_rs1(ins[6:0]) && ins[19:15] == m_rd) ||
          (reads_rs2(ins[6:0]) && ins[24:20] == m_rd));
    rdy = !fl && !hz && (!mv || er);
    check("id_ready", 64'(id_ready), 64'(rdy));
    check("id_ready_m", 64'(id_ready_m), 64'(rdy));
    acc = iv && rdy;
    nv = mv; n_rd = m_rd; n_mr = m_mr; nb0 = mb0; nb1 = mb1;
    if (fl) nv = 1'b0;
    else if (acc) begin
      b0 = ref_decode(ins, pc_ctr, 1'b0);
      b1 = ref_decode(ins, pc_ctr, 1'b1);
      q.push_back({b0, b1});
      nv = 1'b1; n_rd = ins[11:7]; n_mr = b0.mem_read;
    end else if (er) nv = 1'b0;
    if (hz && er && iv && !fl) begin
      nb0 = (mb0 < 65535) ? mb0 + 1 : mb0;
      nb1 = (mb1 < 7) ? mb1 + 1 : mb1;
    end
    pc_ctr += 4;
    @(posedge clk); #1;
    mv = nv; m_rd = n_rd; m_mr = n_mr; mb0 = nb0; mb1 = nb1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b0;
    #1;
    check("rst_ex_valid", 64'(ex_valid), 64'd0);
    check("rst_bundle", act0, 64'd0);
    check("rst_bubble", 64'(bubble_cnt), 64'd0);
    check("rst_ex_valid_m", 64'(ex_valid_m), 64'd0);
    check("rst_bundle_m", act1, 64'd0);
    check("rst_bubble_m", 64'(bubble_cnt_m), 64'd0);
    q.delete();
    mv = 1'b0; m_mr = 1'b0; m_rd = '0; mb0 = 0; mb1 = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      check("ex_valid", 64'(ex_valid), 64'(mv));
      check("ex_valid_m", 64'(ex_valid_m), 64'(mv));
      check("bubble_cnt", 64'(bubble_cnt), 64'(mb0));
      check("bubble_cnt_m", 64'(bubble_cnt_m), 64'(mb1));
      if (ex_valid && (ex_ready || flush)) begin
        if (q.size() == 0) begin
          check("queue_nonempty", 64'd0, 64'd1);
        end else begin
          mon_e = q.pop_front();
          check("entry", act0, mon_e.b0);
          check("entry_m", act1, mon_e.b1);
        end
      end
    end
  end

  // ---------------- instruction builders ----------------
  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [31:0] w;
    logic [6:0] ops [12];
    int k;
    ops = '{7'h33, 7'h33, 7'h13, 7'h03, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h0F, 7'h7F};
    w = $urandom;
    k = $urandom_range(0, 12);
    w[6:0]   = (k == 12) ? 7'($urandom) : ops[k];
    w[11:7]  = 5'($urandom_range(0, 3));
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    if (w[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: w[31:25] = 7'($urandom);
      endcase
    end
    return w;
  endfunction

  logic [31:0] nop_w;

  initial begin
    nop_w = i_ins(12'd0, 5'd0, 3'b000, 5'd0, 7'h13);
    #3;
    do_reset();

    // back-to-back: add x3,x1,x2 ; addi x4,x3,5
    cycle(1'b1, r_ins(7'h00, 5'd2, 5'd1, 5'd3), 1'b0, 1'b1);
    cycle(1'b1, i_ins(12'd5, 5'd3, 3'b000, 5'd4, 7'h13), 1'b0, 1'b1);
    // load-use: lw x5,0(x1) ; add x6,x5,x2 (retried after the bubble)
    cycle(1'b1, i_ins(12'd0, 5'd1, 3'b010, 5'd5, 7'h03), 1'b0, 1'b1);
    cycle(1'b1, r_ins(7'h00, 5'd2, 5'd5, 5'd6), 1'b0, 1'b1);
    cycle(1'b1, r_ins(7'h00, 5'd2, 5'd5, 5'd6), 1'b0, 1'b1);
    // lw x0 then add x6,x0,x0 : no hazard
    cycle(1'b1, i_ins(12'd0, 5'd1, 3'b010, 5'd0, 7'h03), 1'b0, 1'b1);
    cycle(1'b1, r_ins(7'h00, 5'd0, 5'd0, 5'd6), 1'b0, 1'b1);
    // lw x5 then lui x5,1 : no hazard
    cycle(1'b1, i_ins(12'd0, 5'd1, 3'b010, 5'd5, 7'h03), 1'b0, 1'b1);
    cycle(1'b1, {20'd1, 5'd5, 7'h37}, 1'b0, 1'b1);
    // backpressure: sw x2,0(x1) held for 3 cycles
    cycle(1'b1, {7'd0, 5'd2, 5'd1, 3'b010, 5'd0, 7'h23}, 1'b0, 1'b1);
    repeat (3) cycle(1'b1, nop_w, 1'b0, 1'b0);
    cycle(1'b1, nop_w, 1'b0, 1'b1);
    // flush with a held branch while an add is incoming
    cycle(1'b1, {7'd0, 5'd2, 5'd1, 3'b000, 5'd0, 7'h63}, 1'b0, 1'b1);
    cycle(1'b1, r_ins(7'h00, 5'd2, 5'd1, 5'd9), 1'b1, 1'b0);
    cycle(1'b0, nop_w, 1'b0, 1'b1);
    // illegal opcode, mul, bad funct7, fence
    cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    cycle(1'b1, r_ins(7'h01, 5'd2, 5'd1, 5'd7), 1'b0, 1'b1);
    cycle(1'b1, r_ins(7'h7F, 5'd2, 5'd1, 5'd7), 1'b0, 1'b1);
    cycle(1'b1, 32'h0FF0_000F, 1'b0, 1'b1);
    cycle(1'b1, r_ins(7'h20, 5'd2, 5'd1, 5'd8), 1'b0, 1'b1);
    // reset mid-stream with a held entry
    do_reset();
    cycle(1'b1, r_ins(7'h00, 5'd2, 5'd1, 5'd3), 1'b0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      cycle(($urandom_range(0, 9) < 8), rand_ins(), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 3) != 0));
    end

    // drain
    repeat (3) cycle(1'b0, nop_w, 1'b0, 1'b1);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/id_ctrl_stage.md
# id_ctrl_stage

Registered decode and control stage for the RV32I five-stage pipeline. It sits between the IF/ID register and the execute stage. It decodes opcode, funct3 and funct7 into the control bundle and holds that bundle in an ID/EX register with a valid/ready handshake. It also detects load-use hazards and inserts bubbles, handles flushes, flags illegal encodings, optionally decodes the M extension, and counts inserted bubbles.

## Interface
- XLEN, 32, width of the PC field carried with the instruction
- EN_M, 0, 1 = decode RV32M (funct7 = 0000001 in R-type) as legal
- CNT_W, 16, width of the saturating bubble counter
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_valid  in  1  IF/ID holds a valid instruction
- instr  in  32  instruction word
- if_pc  in  XLEN  PC of instr
- id_ready  out  1  stage accepts instr this cycle (combinational)
- flush  in  1  kill the held entry and the incoming instruction (branch/jump redirect)
- ex_ready  in  1  execute stage consumes the held entry this cycle
- ex_valid  out  1  ID/EX register holds a valid entry
- ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_jump  out  1 each  control bits
- ex_alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded, 11 M-extension (EN_M only)
- ex_imm_type  out  3  000 I, 001 S, 010 B, 011 U, 100 J, 111 none
- ex_rd, ex_rs1, ex_rs2  out  5 each  register addresses
- ex_funct3  out  3  instr[14:12]
- ex_funct7_5  out  1  instr[30]
- ex_pc  out  XLEN  PC of held entry
- ex_illegal  out  1  held entry is an illegal encoding
- bubble_cnt  out  CNT_W  load-use bubbles inserted since reset, saturating

## Operation
- Decode per opcode:
  - R 0110011: alu_src 0, alu_op 10, reg_write 1, imm 111.
  - I 0010011: alu_src 1, alu_op 10, reg_write 1, imm 000.
  - Load 0000011: alu_src 1, alu_op 00, mem_read 1, reg_write 1, mem_to_reg 1, imm 000.
  - Store 0100011: alu_src 1, alu_op 00, mem_write 1, imm 001.
  - Branch 1100011: alu_src 0, alu_op 01, branch 1, imm 010.
  - JAL 1101111: jump 1, reg_write 1, imm 100.
  - JALR 1100111: alu_src 1, jump 1, reg_write 1, imm 000.
  - LUI 0110111 and AUIPC 0010111: alu_src 1, reg_write 1, imm 011.
  - FENCE 0001111: legal no-op, all control bits 0.
- Every don't-care control bit is driven 0.
- Illegal encodings: any other opcode, and R-type funct7 not in {0000000, 0100000}. Exception: funct7 = 0000001 is legal when EN_M = 1, and then alu_op = 11.
- An illegal instruction gets ex_illegal = 1 with all control bits 0. It still propagates with ex_valid = 1.
- Register use:
  - rs1 is used by R, I, Load, Store, Branch and JALR.
  - rs2 is used by R, Store and Branch.
- Load-use hazard (hz) = ex_valid & ex_mem_read & (ex_rd != 0) & ((rs1 used & rs1 == ex_rd) | (rs2 used & rs2 == ex_rd)), evaluated against the incoming instr.
- id_ready = !flush & !hz & (!ex_valid | ex_ready).
- Accept = if_valid & id_ready. On accept, the ID/EX register loads the decoded bundle and ex_valid <= 1.
- If there is no accept and ex_ready = 1, ex_valid <= 0.
- If ex_valid = 1 and ex_ready = 0, the held entry and all ex_* outputs stay stable.
- Bubble: when hz & ex_ready & if_valid & !flush:
  - ex_valid <= 0;
  - bubble_cnt increments, saturating at 2^CNT_W − 1.
- Flush has priority over accept and hazard: ex_valid <= 0 next cycle, instr is dropped, and bubble_cnt is unchanged.

## Timing
- Latency: the instruction accepted in cycle N appears on ex_* in cycle N+1.
- Throughput: one instruction per cycle without hazards.
- A load-use pair costs exactly one bubble cycle.
- id_ready depends combinationally on ex_ready, flush and instr; there is no combinational path from if_valid to id_ready.
- Reset: rst_n low asynchronously clears ex_valid, all ex_* control bits, ex_illegal and bubble_cnt to 0, and ex_imm_type to 000.
- Reset mid-operation discards the held entry. The first accept can occur in the first clock edge after rst_n deasserts.
- Simultaneous flush and ex_ready with a held entry: the entry is consumed and no new entry loads.

## Test plan
- Back-to-back stream: add x3,x1,x2 then addi x4,x3,5, ex_ready = 1. Required: ex_valid high for 2 consecutive cycles, the first with alu_op 10 / imm 111, the second with alu_src 1 / imm 000, and bubble_cnt = 0.
- Load-use: lw x5,0(x1) then add x6,x5,x2. Required: id_ready = 0 for 1 cycle, one ex_valid = 0 gap, the add issues on the next cycle, and bubble_cnt = 1.
- Hazard immunity cases, each issuing with no bubble:
  - lw x0,0(x1) followed by add x6,x0,x0;
  - lw x5,0(x1) followed by lui x5,1, since LUI uses no rs.
- Backpressure: ex_ready held 0 for 3 cycles while holding sw. Required: ex_* stable, id_ready = 0, and the next instruction accepted in the cycle ex_ready returns to 1.
- Flush with a held branch and if_valid = 1. Required: ex_valid = 0 next cycle, the incoming instr is never issued, and bubble_cnt is unchanged.
- Illegal and M decode:
  - opcode 1111111: ex_illegal = 1 with all control bits 0;
  - mul (funct7 = 0000001) with EN_M = 0: ex_illegal = 1;
  - mul with EN_M = 1: alu_op 11, reg_write 1;
  - rst_n pulsed low mid-stream: all outputs 0 immediately.
